// File: rtl/seq_match_param_if.sv
// Panel-side bundle for seq_match_param: step/bit/pattern controls in, match status out.
// The master drives the controls and observes status; the matcher is the slave.
interface seq_match_param_if #(
  parameter int unsigned PAT_W = 6,
  parameter int unsigned CNT_W = 8
);
  logic             step_i;
  logic             bit_i;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic [PAT_W-1:0] shift_o;
  logic             match_o;
  logic             match_lvl_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic             cnt_sat_o;

  modport master (
    output step_i, bit_i, overlap_en, pat_load, pat_in, cnt_clr,
    input  shift_o, match_o, match_lvl_o, match_cnt_o, cnt_sat_o
  );

  modport slave (
    input  step_i, bit_i, overlap_en, pat_load, pat_in, cnt_clr,
    output shift_o, match_o, match_lvl_o, match_cnt_o, cnt_sat_o
  );
endinterface

// File: rtl/seq_match_param.sv
// Serial pattern matcher: shifts bit_i on each rising edge of step_i and flags when the
// last PAT_W bits equal a runtime-loadable pattern, with a saturating match counter.
module seq_match_param #(
  parameter int unsigned      PAT_W       = 6,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 6'b101011,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic               System_clk,
  input  logic               BTNU,
  seq_match_param_if.slave   bus
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic {
    ST_FILL,
    ST_ARMED
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   shift_q, shift_d, shift_nxt;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               step_q;
  logic               step_edge;
  logic               hit;
  logic               match_q, match_d;
  logic               lvl_q, lvl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic               sat_q, sat_d;

  // Step edge detect, shift/fill candidate and match decision against the current pattern.
  always_comb begin
    step_edge = bus.step_i & ~step_q;
    shift_nxt = {shift_q[PAT_W-2:0], bus.bit_i};
    fill_inc  = (state_q == ST_ARMED) ? FILL_FULL : fill_q + FILL_W'(1);
    hit       = step_edge & ~bus.pat_load & (shift_nxt == pattern_q) & (fill_inc == FILL_FULL);
  end

  // Next state: pattern load beats a coincident step; non-overlap hits restart the fill.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pattern_d = pattern_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    lvl_d     = lvl_q;

    if (bus.pat_load) begin
      pattern_d = bus.pat_in;
      shift_d   = '0;
      fill_d    = '0;
      lvl_d     = 1'b0;
      state_d   = ST_FILL;
    end else if (step_edge) begin
      shift_d = shift_nxt;
      match_d = hit;
      lvl_d   = hit;
      if (hit && !bus.overlap_en) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_FULL) ? ST_ARMED : ST_FILL;
      end
    end
  end

  // Clear-then-count so a hit coinciding with cnt_clr leaves the counter at one.
  always_comb begin
    cnt_base = bus.cnt_clr ? '0 : cnt_q;
    cnt_d    = (hit && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;
    sat_d    = &cnt_d;
  end

  // step_q resets high so a step held through reset release is not seen as an edge.
  always_ff @(posedge System_clk) begin
    if (BTNU) begin
      state_q   <= ST_FILL;
      shift_q   <= '0;
      pattern_q <= PAT_DEFAULT;
      fill_q    <= '0;
      step_q    <= 1'b1;
      match_q   <= 1'b0;
      lvl_q     <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      step_q    <= bus.step_i;
      match_q   <= match_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.shift_o     = shift_q;
  assign bus.match_o     = match_q;
  assign bus.match_lvl_o = lvl_q;
  assign bus.match_cnt_o = cnt_q;
  assign bus.cnt_sat_o   = sat_q;

endmodule

// File: tb/tb_seq_match_param.sv
// Directed bench for seq_match_param: a default build plus a CNT_W=2 build fed identical
// stimulus, so counter saturation is observed alongside the main matching behaviour.
module tb_seq_match_param;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic last_m;
  int   hits;
  logic [8:0] seq9;

  always #5 clk = ~clk;

  seq_match_param_if #(.PAT_W(6), .CNT_W(8)) b1 ();
  seq_match_param_if #(.PAT_W(6), .CNT_W(2)) b2 ();

  assign b2.step_i     = b1.step_i;
  assign b2.bit_i      = b1.bit_i;
  assign b2.overlap_en = b1.overlap_en;
  assign b2.pat_load   = b1.pat_load;
  assign b2.pat_in     = b1.pat_in;
  assign b2.cnt_clr    = b1.cnt_clr;

  seq_match_param #(.PAT_W(6), .PAT_DEFAULT(6'b101011), .CNT_W(8)) u1 (
    .System_clk (clk),
    .BTNU       (rst),
    .bus        (b1.slave)
  );

  seq_match_param #(.PAT_W(6), .PAT_DEFAULT(6'b101011), .CNT_W(2)) u2 (
    .System_clk (clk),
    .BTNU       (rst),
    .bus        (b2.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One step pulse: rising edge on this cycle, match sampled one clock later, then low.
  task automatic pulse(input logic b, input logic clr);
    b1.bit_i   = b;
    b1.cnt_clr = clr;
    b1.step_i  = 1'b1;
    tick();
    last_m     = b1.match_o;
    b1.cnt_clr = 1'b0;
    b1.step_i  = 1'b0;
    tick();
  endtask

  task automatic load(input logic [5:0] p);
    b1.pat_in   = p;
    b1.pat_load = 1'b1;
    tick();
    b1.pat_load = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    b1.step_i     = 1'b0;
    b1.bit_i      = 1'b0;
    b1.overlap_en = 1'b1;
    b1.pat_load   = 1'b0;
    b1.pat_in     = '0;
    b1.cnt_clr    = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_shift", 32'(b1.shift_o), 32'h0);
    chk("rst_match", 32'(b1.match_o), 32'h0);
    chk("rst_lvl",   32'(b1.match_lvl_o), 32'h0);
    chk("rst_cnt",   32'(b1.match_cnt_o), 32'h0);
    chk("rst_sat",   32'(b1.cnt_sat_o), 32'h0);

    // Default pattern 101011
    hits = 0;
    pulse(1'b1, 1'b0); hits += int'(last_m);
    pulse(1'b0, 1'b0); hits += int'(last_m);
    pulse(1'b1, 1'b0); hits += int'(last_m);
    pulse(1'b0, 1'b0); hits += int'(last_m);
    pulse(1'b1, 1'b0); hits += int'(last_m);
    chk("t1_no_early", 32'(hits), 32'd0);
    pulse(1'b1, 1'b0);
    chk("t1_match",  32'(last_m), 32'h1);
    chk("t1_pulse_end", 32'(b1.match_o), 32'h0);
    chk("t1_lvl",    32'(b1.match_lvl_o), 32'h1);
    chk("t1_cnt",    32'(b1.match_cnt_o), 32'd1);
    chk("t1_shift",  32'(b1.shift_o), 32'h2B);

    // Overlapping 110110 over 110110110
    load(6'b110110);
    chk("t2_load_shift", 32'(b1.shift_o), 32'h0);
    chk("t2_load_lvl",   32'(b1.match_lvl_o), 32'h0);
    chk("t2_load_cnt",   32'(b1.match_cnt_o), 32'd1);
    seq9 = 9'b110110110;
    hits = 0;
    for (int i = 8; i >= 0; i--) begin
      pulse(seq9[i], 1'b0);
      hits += int'(last_m);
    end
    chk("t2_ovl_hits", 32'(hits), 32'd2);
    chk("t2_ovl_cnt",  32'(b1.match_cnt_o), 32'd3);
    chk("t2_small_cnt", 32'(b2.match_cnt_o), 32'd3);
    chk("t2_small_sat", 32'(b2.cnt_sat_o), 32'h1);
    chk("t2_big_sat",   32'(b1.cnt_sat_o), 32'h0);

    b1.cnt_clr = 1'b1;
    tick();
    b1.cnt_clr = 1'b0;
    chk("clr_cnt",       32'(b1.match_cnt_o), 32'd0);
    chk("clr_small_sat", 32'(b2.cnt_sat_o), 32'h0);
    chk("clr_keep_lvl",  32'(b1.match_lvl_o), 32'h1);

    // Non-overlapping: only the first 110110 counts
    b1.overlap_en = 1'b0;
    load(6'b110110);
    hits = 0;
    for (int i = 8; i >= 0; i--) begin
      pulse(seq9[i], 1'b0);
      hits += int'(last_m);
    end
    chk("t2_novl_hits", 32'(hits), 32'd1);
    chk("t2_novl_cnt",  32'(b1.match_cnt_o), 32'd1);
    chk("t2_novl_lvl",  32'(b1.match_lvl_o), 32'h0);

    // All-zero pattern: fill guard, then saturation on the CNT_W=2 build
    b1.overlap_en = 1'b1;
    load(6'b000000);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b0);
      hits += int'(last_m);
    end
    chk("t3_fill_guard", 32'(hits), 32'd0);
    pulse(1'b0, 1'b0);
    chk("t3_match6", 32'(last_m), 32'h1);
    chk("t3_cnt6",   32'(b1.match_cnt_o), 32'd2);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    chk("t5_big_cnt",   32'(b1.match_cnt_o), 32'd4);
    chk("t5_small_cnt", 32'(b2.match_cnt_o), 32'd3);
    chk("t5_small_sat", 32'(b2.cnt_sat_o), 32'h1);
    pulse(1'b0, 1'b1);
    chk("t5_clr_hit_m",    32'(last_m), 32'h1);
    chk("t5_clr_hit_big",  32'(b1.match_cnt_o), 32'd1);
    chk("t5_clr_hit_cnt",  32'(b2.match_cnt_o), 32'd1);
    chk("t5_clr_hit_sat",  32'(b2.cnt_sat_o), 32'h0);

    // Step held high for 100 cycles shifts once; bit toggles without a step do nothing
    b1.bit_i  = 1'b1;
    b1.step_i = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    b1.step_i = 1'b0;
    tick();
    chk("t4_held_shift", 32'(b1.shift_o), 32'h01);
    chk("t4_held_cnt",   32'(b1.match_cnt_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      b1.bit_i = ~b1.bit_i;
      tick();
    end
    chk("t4_toggle_shift", 32'(b1.shift_o), 32'h01);

    // Reset mid-pattern with step held high across release
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    b1.bit_i  = 1'b1;
    b1.step_i = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    b1.step_i = 1'b0;
    tick();
    chk("t6_rst_shift", 32'(b1.shift_o), 32'h0);
    chk("t6_rst_match", 32'(b1.match_o), 32'h0);
    chk("t6_rst_lvl",   32'(b1.match_lvl_o), 32'h0);
    chk("t6_rst_cnt",   32'(b1.match_cnt_o), 32'd0);
    chk("t6_rst_small", 32'(b2.match_cnt_o), 32'd0);
    hits = 0;
    pulse(1'b1, 1'b0); hits += int'(last_m);
    pulse(1'b0, 1'b0); hits += int'(last_m);
    pulse(1'b1, 1'b0); hits += int'(last_m);
    pulse(1'b0, 1'b0); hits += int'(last_m);
    pulse(1'b1, 1'b0); hits += int'(last_m);
    chk("t6_no_early", 32'(hits), 32'd0);
    pulse(1'b1, 1'b0);
    chk("t6_default_pat", 32'(last_m), 32'h1);
    chk("t6_lvl",         32'(b1.match_lvl_o), 32'h1);

    // pat_load coincident with a step edge: the step bit is dropped
    b1.pat_in   = 6'b111111;
    b1.pat_load = 1'b1;
    b1.bit_i    = 1'b1;
    b1.step_i   = 1'b1;
    tick();
    b1.pat_load = 1'b0;
    tick();
    b1.step_i = 1'b0;
    tick();
    chk("t6_ld_shift", 32'(b1.shift_o), 32'h0);
    chk("t6_ld_lvl",   32'(b1.match_lvl_o), 32'h0);
    chk("t6_ld_match", 32'(b1.match_o), 32'h0);
    chk("t6_ld_cnt",   32'(b1.match_cnt_o), 32'd1);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0);
      hits += int'(last_m);
    end
    chk("t6_ld_discard", 32'(hits), 32'd0);
    pulse(1'b1, 1'b0);
    chk("t6_ld_match6", 32'(last_m), 32'h1);
    chk("t6_ld_cnt2",   32'(b1.match_cnt_o), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
